uart_cmd_tx: RTL and testbench

//  Host-side command transmitter: the initiator end of the UART monitor protocol.

---
 rtl/uart_cmd_pkg.sv | 58 +++++
 rtl/uart_cmd_if.sv | 26 ++
 rtl/uart_tx_ser.sv | 59 +++++
 rtl/uart_cmd_tx.sv | 158 +++++++++++++++
 tb/tb_uart_cmd_tx.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART monitor command transmitter: opcodes, FSM states,
// ASCII constants, the latched command payload and nibble/character helpers.
package uart_cmd_pkg;

  localparam int unsigned OP_W      = 2;
  localparam int unsigned ADR_W     = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned NIB_CNT_W = 3;
  localparam int unsigned STATE_W   = 3;

  localparam logic [OP_W-1:0] OP_WADR = 2'b00;
  localparam logic [OP_W-1:0] OP_DATA = 2'b01;
  localparam logic [OP_W-1:0] OP_READ = 2'b10;
  localparam logic [OP_W-1:0] OP_GO   = 2'b11;

  // Each state names the character currently on the wire
  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_OPCH = 3'd1;
  localparam logic [STATE_W-1:0] ST_SP1  = 3'd2;
  localparam logic [STATE_W-1:0] ST_HEXA = 3'd3;
  localparam logic [STATE_W-1:0] ST_SP2  = 3'd4;
  localparam logic [STATE_W-1:0] ST_HEXB = 3'd5;
  localparam logic [STATE_W-1:0] ST_CR   = 3'd6;
  localparam logic [STATE_W-1:0] ST_LF   = 3'd7;

  localparam logic [CHAR_W-1:0] ASC_CR = 8'h0d;
  localparam logic [CHAR_W-1:0] ASC_LF = 8'h0a;
  localparam logic [CHAR_W-1:0] ASC_SP = 8'h20;
  localparam logic [CHAR_W-1:0] ASC_W  = 8'h77;
  localparam logic [CHAR_W-1:0] ASC_R  = 8'h72;
  localparam logic [CHAR_W-1:0] ASC_G  = 8'h67;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  function automatic logic [CHAR_W-1:0] nib2asc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h57 + {4'h0, n};
  endfunction

  function automatic logic [3:0] nib_sel(input logic [31:0] w, input logic [NIB_CNT_W-1:0] i);
    return w[{i, 2'b00} +: 4];
  endfunction

  // DATA lines carry no opcode character, so only three letters exist
  function automatic logic [CHAR_W-1:0] op_char(input logic [OP_W-1:0] op);
    case (op)
      OP_WADR: return ASC_W;
      OP_READ: return ASC_R;
      default: return ASC_G;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_if.sv
// Command handshake between a host and the UART command transmitter.
interface uart_cmd_if;

  logic                                cmd_valid;
  logic                                cmd_ready;
  logic [uart_cmd_pkg::OP_W-1:0]       cmd_op;
  logic [uart_cmd_pkg::ADR_W-1:0]      cmd_adr;
  logic [uart_cmd_pkg::DATA_W-1:0]     cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_adr,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_adr,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/uart_tx_ser.sv
// 8N1 serializer: start bit, eight data bits LSB first, stop bit, each held BAUD_DIV cycles.
// A new character may be loaded in the cycle char_done is high for gap-free streaming.
module uart_tx_ser #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_load,
  output logic       char_done,
  output logic       tx
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W = 4;
  localparam logic [BIT_W-1:0] LAST_BIT = 4'd9;
  localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(BAUD_DIV - 1);

  logic             active;
  logic [8:0]       shreg;
  logic [BIT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] baud_cnt;
  logic             bit_end_c;
  logic             char_end_c;

  assign bit_end_c  = active && (baud_cnt == '0);
  assign char_end_c = bit_end_c && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active    <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
      tx        <= 1'b1;
      char_done <= 1'b0;
    end else begin
      // Registered one cycle early so it coincides with the final stop-bit cycle
      char_done <= active && (bit_cnt == LAST_BIT) && (baud_cnt == CNT_W'(1));
      if (char_load && (!active || char_end_c)) begin
        tx       <= 1'b0;
        shreg    <= {1'b1, char_in};
        bit_cnt  <= '0;
        baud_cnt <= BAUD_MAX;
        active   <= 1'b1;
      end else if (char_end_c) begin
        active   <= 1'b0;
      end else if (bit_end_c) begin
        tx       <= shreg[0];
        shreg    <= {1'b0, shreg[8:1]};
        bit_cnt  <= bit_cnt + BIT_W'(1);
        baud_cnt <= BAUD_MAX;
      end else if (active) begin
        baud_cnt <= baud_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_cmd_tx.sv
// Host-side UART monitor command transmitter: formats one command as an ASCII hex line
// and streams it through the 8N1 serializer.
module uart_cmd_tx
  import uart_cmd_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic      clk,
  input  logic      rst,
  uart_cmd_if.slave cmd,
  output logic      tx,
  output logic      busy,
  output logic      done
);

  logic [STATE_W-1:0]   state_q;
  logic [STATE_W-1:0]   state_n;
  logic [NIB_CNT_W-1:0] nib_q;
  logic [NIB_CNT_W-1:0] nib_n;
  logic [NIB_CNT_W-1:0] nib_dn_c;
  cmd_t                 cmd_q;
  logic                 ready_q;
  logic                 accept_c;
  logic                 load_c;
  logic [CHAR_W-1:0]    char_c;
  logic                 char_done;

  assign cmd.cmd_ready = ready_q;
  assign accept_c      = cmd.cmd_valid && ready_q;
  assign nib_dn_c      = nib_q - NIB_CNT_W'(1);

  uart_tx_ser #(
    .BAUD_DIV (BAUD_DIV)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .char_in   (char_c),
    .char_load (load_c),
    .char_done (char_done),
    .tx        (tx)
  );

  // FSM state and nibble counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      nib_q   <= '0;
    end else begin
      state_q <= state_n;
      nib_q   <= nib_n;
    end
  end

  // Next state and the character handed to the serializer on each transition
  always_comb begin
    state_n = state_q;
    nib_n   = nib_q;
    load_c  = 1'b0;
    char_c  = ASC_SP;
    case (state_q)
      ST_IDLE: begin
        // First character comes straight from the inputs so tx starts next cycle
        if (accept_c) begin
          load_c = 1'b1;
          if (cmd.cmd_op == OP_DATA) begin
            state_n = ST_HEXB;
            nib_n   = 3'd7;
            char_c  = nib2asc(cmd.cmd_data[31:28]);
          end else begin
            state_n = ST_OPCH;
            char_c  = op_char(cmd.cmd_op);
          end
        end
      end
      ST_OPCH: begin
        if (char_done) begin
          load_c  = 1'b1;
          state_n = ST_SP1;
          char_c  = ASC_SP;
        end
      end
      ST_SP1: begin
        if (char_done) begin
          load_c  = 1'b1;
          state_n = ST_HEXA;
          nib_n   = 3'd7;
          char_c  = nib2asc(cmd_q.adr[31:28]);
        end
      end
      ST_HEXA: begin
        if (char_done) begin
          load_c = 1'b1;
          if (nib_q != '0) begin
            nib_n  = nib_dn_c;
            char_c = nib2asc(nib_sel(cmd_q.adr, nib_dn_c));
          end else if (cmd_q.op == OP_READ) begin
            state_n = ST_SP2;
            char_c  = ASC_SP;
          end else begin
            state_n = ST_CR;
            char_c  = ASC_CR;
          end
        end
      end
      ST_SP2: begin
        if (char_done) begin
          load_c  = 1'b1;
          state_n = ST_HEXB;
          nib_n   = 3'd7;
          char_c  = nib2asc(cmd_q.data[31:28]);
        end
      end
      ST_HEXB: begin
        if (char_done) begin
          load_c = 1'b1;
          if (nib_q != '0) begin
            nib_n  = nib_dn_c;
            char_c = nib2asc(nib_sel(cmd_q.data, nib_dn_c));
          end else begin
            state_n = ST_CR;
            char_c  = ASC_CR;
          end
        end
      end
      ST_CR: begin
        if (char_done) begin
          load_c  = 1'b1;
          state_n = ST_LF;
          char_c  = ASC_LF;
        end
      end
      ST_LF: begin
        if (char_done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Latched command, handshake and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q   <= '0;
      ready_q <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (accept_c) begin
        cmd_q.op   <= cmd.cmd_op;
        cmd_q.adr  <= cmd.cmd_adr;
        cmd_q.data <= cmd.cmd_data;
      end
      ready_q <= (state_n == ST_IDLE);
      busy    <= (state_n != ST_IDLE);
      done    <= (state_q == ST_LF) && char_done;
    end
  end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Scoreboard bench for uart_cmd_tx: the driver queues expected characters and done
// cycles per accepted command; a line monitor decodes tx and checks against them.
module tb_uart_cmd_tx;
  import uart_cmd_pkg::*;

  localparam int unsigned BAUD     = 4;
  localparam int          CHAR_CYC = 10 * BAUD;

  typedef struct {
    logic [7:0] ch;
    int         start;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  logic busy;
  logic done;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;
  int   last_start = 0;
  exp_t exp_q[$];
  int   done_q[$];

  uart_cmd_if bus ();

  uart_cmd_tx #(
    .BAUD_DIV (BAUD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (bus),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected line text built independently with $sformatf
  task automatic push_line(input logic [1:0] op, input logic [31:0] adr,
                           input logic [31:0] data, input int start);
    string s;
    exp_t  e;
    int    n;
    case (op)
      OP_WADR: s = $sformatf("w %08x", adr);
      OP_DATA: s = $sformatf("%08x", data);
      OP_READ: s = $sformatf("r %08x %08x", adr, data);
      default: s = $sformatf("g %08x", adr);
    endcase
    n = s.len() + 2;
    for (int i = 0; i < s.len(); i++) begin
      e.ch = s[i];
      e.start = start + i * CHAR_CYC;
      exp_q.push_back(e);
    end
    e.ch = 8'h0d; e.start = start + (n - 2) * CHAR_CYC; exp_q.push_back(e);
    e.ch = 8'h0a; e.start = start + (n - 1) * CHAR_CYC; exp_q.push_back(e);
    done_q.push_back(start + n * CHAR_CYC);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] adr,
                      input logic [31:0] data, input bit hold);
    int w;
    bus.cmd_op    = op;
    bus.cmd_adr   = adr;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    last_start = cyc + 1;
    push_line(op, adr, data, last_start);
    @(negedge clk);
    check("ready_drop", bus.cmd_ready, 32'd0);
    check("busy_rise", busy, 32'd1);
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((bus.cmd_ready !== 1'b1 || exp_q.size() != 0 || done_q.size() != 0) && w < 4000) begin
      @(negedge clk);
      w++;
    end
    check("idle_timeout", (w < 4000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Line monitor: 40 samples per character, bit widths, framing, value and start cycle
  initial begin : monitor
    logic [39:0] bits;
    logic [7:0]  ch;
    logic        frame_ok;
    int          nb;
    int          st;
    bit          act;
    exp_t        e;
    act = 1'b0;
    nb  = 0;
    st  = 0;
    bits = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        act = 1'b0;
        nb  = 0;
      end else begin
        if (done === 1'b1) begin
          if (done_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
          else check("done_cycle", cyc, done_q.pop_front());
        end
        if (!act) begin
          if (tx === 1'b0) begin
            act = 1'b1;
            st  = cyc;
            bits[0] = tx;
            nb  = 1;
          end
        end else begin
          bits[nb] = tx;
          nb++;
          if (nb == CHAR_CYC) begin
            act = 1'b0;
            frame_ok = 1'b1;
            for (int k = 0; k < 10; k++)
              for (int j = 0; j < BAUD; j++)
                if (bits[k*BAUD+j] !== bits[k*BAUD]) frame_ok = 1'b0;
            if (bits[9*BAUD] !== 1'b1) frame_ok = 1'b0;
            for (int j = 0; j < 8; j++) ch[j] = bits[(j+1)*BAUD];
            check("char_frame", frame_ok, 32'd1);
            if (exp_q.size() == 0) begin
              check("char_unexpected", ch, 32'h100);
            end else begin
              e = exp_q.pop_front();
              check("char_value", ch, e.ch);
              check("char_start", st, e.start);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_adr   = '0;
    bus.cmd_data  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 32'd1);
    check("reset_ready", bus.cmd_ready, 32'd1);
    check("reset_busy", busy, 32'd0);
    check("reset_done", done, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    send(OP_WADR, 32'h0000_0100, 32'hffff_ffff, 1'b0);
    wait_idle();
    send(OP_READ, 32'h0000_0000, 32'h0000_00fc, 1'b0);
    wait_idle();
    send(OP_DATA, 32'h5555_aaaa, 32'hdead_beef, 1'b0);
    wait_idle();

    // Back-to-back with valid held high
    send(OP_GO, 32'h0000_0000, 32'h0, 1'b1);
    send(OP_WADR, 32'h0000_0010, 32'h0, 1'b0);
    wait_idle();

    // Fields and valid churn while busy must be ignored
    send(OP_READ, 32'h0000_1000, 32'h0000_10ff, 1'b0);
    repeat (60) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_op    = 2'($urandom);
      bus.cmd_adr   = $urandom;
      bus.cmd_data  = $urandom;
      @(negedge clk);
      check("ready_while_busy", bus.cmd_ready, 32'd0);
    end
    bus.cmd_valid = 1'b0;
    wait_idle();

    // Reset in the middle of the address field
    send(OP_WADR, 32'h1234_5678, 32'h0, 1'b0);
    while (cyc < last_start + 81) @(negedge clk);
    check("pre_rst_tx", tx, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_tx_async", tx, 32'd1);
    check("rst_ready_async", bus.cmd_ready, 32'd1);
    check("rst_busy_async", busy, 32'd0);
    exp_q.delete();
    done_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("rst_no_done", done, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus.cmd_ready, 32'd1);
    check("post_rst_busy", busy, 32'd0);
    check("post_rst_tx", tx, 32'd1);

    send(OP_GO, 32'hcafe_f00d, 32'h0, 1'b0);
    wait_idle();
    repeat (5) @(negedge clk);
    check("chars_left", exp_q.size(), 32'd0);
    check("dones_left", done_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
